aesip_axil_regs: RTL and testbench

AXI4-Lite slave register front end of the AES IP. It decodes single-beat reads and writes from the bus master into key, plaintext/ciphertext and control registers, and hands a 128-bit key and block to the AES core with a one-cycle start pulse. It captures the core's 128-bit result and done event into read-only status and output registers. It sits directly downstream of the AXI master/VIP and directly upstream of the AES round core.

---
 rtl/aesip_pkg.sv | 48 ++++
 rtl/aesip_axil_rdmux.sv | 36 +++
 rtl/aesip_axil_regs.sv | 258 +++++++++++++++++++++++++
 tb/tb_aesip_axil_regs.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aesip_pkg.sv
// Purpose: shared register map, AXI response codes, FSM state types and byte-merge helper for the AES AXI-Lite front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aesip_pkg;

    // Byte offsets of the register map; word index is offset[5:2].
    localparam logic [5:0] OFS_CTRL   = 6'h00;
    localparam logic [5:0] OFS_STATUS = 6'h04;
    localparam logic [5:0] OFS_KEY0   = 6'h10;
    localparam logic [5:0] OFS_DIN0   = 6'h20;
    localparam logic [5:0] OFS_DOUT0  = 6'h30;

    // CTRL and STATUS bit positions.
    localparam int CTRL_START = 0;
    localparam int CTRL_MODE  = 1;
    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_ERR   = 2;

    // AXI response codes.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_e;

    // Byte-lane merge of a strobed write onto the current register value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/aesip_axil_rdmux.sv
// Purpose: selects read data and response for a register word index.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller registers the result on AR acceptance.
module aesip_axil_rdmux
    import aesip_pkg::*;
(
    input  logic [3:0]       idx_i,
    input  logic [31:0]      ctrl_i,
    input  logic [31:0]      status_i,
    input  logic [3:0][31:0] key_i,
    input  logic [3:0][31:0] din_i,
    input  logic [3:0][31:0] dout_i,
    output logic [31:0]      rdata_o,
    output logic [1:0]       rresp_o
);

    // Decode word index; the two holes at 0x08/0x0C read as zero with SLVERR.
    always_comb begin
        rdata_o = '0;
        rresp_o = RESP_OKAY;
        if (idx_i == OFS_CTRL[5:2]) begin
            rdata_o = ctrl_i;
        end else if (idx_i == OFS_STATUS[5:2]) begin
            rdata_o = status_i;
        end else if (idx_i[3:2] == OFS_KEY0[5:4]) begin
            rdata_o = key_i[idx_i[1:0]];
        end else if (idx_i[3:2] == OFS_DIN0[5:4]) begin
            rdata_o = din_i[idx_i[1:0]];
        end else if (idx_i[3:2] == OFS_DOUT0[5:4]) begin
            rdata_o = dout_i[idx_i[1:0]];
        end else begin
            rresp_o = RESP_SLVERR;
        end
    end

endmodule

// File: rtl/aesip_axil_regs.sv
// Purpose: AXI4-Lite register front end for the AES core (key/data/control in, result/status out).
// Latency: write update on the cycle AW and W are both held, BVALID next cycle; RVALID one cycle after AR.
// Backpressure: one outstanding write and one outstanding read; ready signals stay low until B/R handshake.
module aesip_axil_regs
    import aesip_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RVALID,
    input  logic                RREADY,
    output logic [127:0]        core_key,
    output logic [127:0]        core_din,
    output logic                core_mode,
    output logic                core_start,
    input  logic [127:0]        core_dout,
    input  logic                core_done
);

    wr_state_e        wstate_q;
    rd_state_e        rstate_q;
    logic [3:0]       awidx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic             awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]       bresp_q, rresp_q;
    logic [31:0]      rdata_q;
    logic             mode_q, busy_q, done_q, err_q, start_q;
    logic             busy_d, done_d, err_d;
    logic [3:0][31:0] key_q, din_q, dout_q;

    logic             aw_hs, w_hs, wr_fire;
    logic [3:0]       wr_idx;
    logic [31:0]      wr_dat;
    logic [3:0]       wr_stb;
    logic [1:0]       wr_resp;
    logic             set_err, start_fire, mode_we, clr_done, clr_err;
    logic [3:0]       key_we, din_we;
    logic [31:0]      ctrl_rd, status_rd, rd_dat;
    logic [1:0]       rd_resp;
    logic             unused_bits;

    assign aw_hs   = AWVALID && awready_q;
    assign w_hs    = WVALID && wready_q;
    // The update fires on whichever cycle completes the second of the two handshakes.
    assign wr_fire = (aw_hs || wstate_q == W_ADDR) && (w_hs || wstate_q == W_DATA);
    assign wr_idx  = (wstate_q == W_ADDR) ? awidx_q : AWADDR[5:2];
    assign wr_dat  = (wstate_q == W_DATA) ? wdata_q : WDATA;
    assign wr_stb  = (wstate_q == W_DATA) ? wstrb_q : WSTRB;

    // Write decode: which register changes, error flag and the response code.
    always_comb begin
        wr_resp    = RESP_OKAY;
        set_err    = 1'b0;
        start_fire = 1'b0;
        mode_we    = 1'b0;
        clr_done   = 1'b0;
        clr_err    = 1'b0;
        key_we     = '0;
        din_we     = '0;
        if (wr_fire) begin
            if (wr_idx == OFS_CTRL[5:2]) begin
                if (wr_stb[0]) begin
                    if (busy_q) begin
                        // Re-START while busy is a soft error; touching MODE is rejected.
                        set_err = 1'b1;
                        if (!wr_dat[CTRL_START]) wr_resp = RESP_SLVERR;
                    end else begin
                        mode_we    = 1'b1;
                        start_fire = wr_dat[CTRL_START];
                    end
                end
            end else if (wr_idx == OFS_STATUS[5:2]) begin
                if (wr_stb[0]) begin
                    clr_done = wr_dat[STAT_DONE];
                    clr_err  = wr_dat[STAT_ERR];
                end
            end else if (wr_idx[3:2] == OFS_KEY0[5:4] || wr_idx[3:2] == OFS_DIN0[5:4]) begin
                if (busy_q) begin
                    set_err = 1'b1;
                    wr_resp = RESP_SLVERR;
                end else if (wr_idx[3:2] == OFS_KEY0[5:4]) begin
                    key_we[wr_idx[1:0]] = 1'b1;
                end else begin
                    din_we[wr_idx[1:0]] = 1'b1;
                end
            end else if (wr_idx[3:2] != OFS_DOUT0[5:4]) begin
                wr_resp = RESP_SLVERR;
            end
        end
    end

    // Status next state: a core_done in the same cycle as a DONE clear leaves DONE set.
    always_comb begin
        busy_d = start_fire || (busy_q && !core_done);
        done_d = core_done || (done_q && !clr_done && !start_fire);
        err_d  = set_err || (err_q && !clr_err);
    end

    // Write channel FSM with registered ready/response outputs.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            if (aw_hs) awidx_q <= AWADDR[5:2];
            if (w_hs) begin
                wdata_q <= WDATA;
                wstrb_q <= WSTRB;
            end
            if (wr_fire) begin
                wstate_q  <= W_RESP;
                awready_q <= 1'b0;
                wready_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_resp;
            end else begin
                case (wstate_q)
                    W_IDLE: begin
                        if (aw_hs) begin
                            wstate_q  <= W_ADDR;
                            awready_q <= 1'b0;
                        end else if (w_hs) begin
                            wstate_q <= W_DATA;
                            wready_q <= 1'b0;
                        end
                    end
                    W_RESP: begin
                        if (BREADY) begin
                            wstate_q  <= W_IDLE;
                            awready_q <= 1'b1;
                            wready_q  <= 1'b1;
                            bvalid_q  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Register file, start pulse and result capture.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            key_q   <= '0;
            din_q   <= '0;
            dout_q  <= '0;
        end else begin
            start_q <= start_fire;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (mode_we) mode_q <= wr_dat[CTRL_MODE];
            for (int i = 0; i < 4; i++) begin
                if (key_we[i]) key_q[i] <= merge_bytes(key_q[i], wr_dat, wr_stb);
                if (din_we[i]) din_q[i] <= merge_bytes(din_q[i], wr_dat, wr_stb);
            end
            if (core_done) dout_q <= core_dout;
        end
    end

    // Readback images of CTRL (START always reads 0) and STATUS.
    always_comb begin
        ctrl_rd                = '0;
        ctrl_rd[CTRL_MODE]     = mode_q;
        status_rd              = '0;
        status_rd[STAT_BUSY]   = busy_q;
        status_rd[STAT_DONE]   = done_q;
        status_rd[STAT_ERR]    = err_q;
    end

    aesip_axil_rdmux u_rdmux (
        .idx_i    (ARADDR[5:2]),
        .ctrl_i   (ctrl_rd),
        .status_i (status_rd),
        .key_i    (key_q),
        .din_i    (din_q),
        .dout_i   (dout_q),
        .rdata_o  (rd_dat),
        .rresp_o  (rd_resp)
    );

    // Read channel FSM; data is sampled from the registers at AR acceptance.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (ARVALID) begin
                        rstate_q  <= R_RESP;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_dat;
                        rresp_q   <= rd_resp;
                    end
                end
                R_RESP: begin
                    if (RREADY) begin
                        rstate_q  <= R_IDLE;
                        arready_q <= 1'b1;
                        rvalid_q  <= 1'b0;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign AWREADY    = awready_q;
    assign WREADY     = wready_q;
    assign BVALID     = bvalid_q;
    assign BRESP      = bresp_q;
    assign ARREADY    = arready_q;
    assign RVALID     = rvalid_q;
    assign RDATA      = rdata_q;
    assign RRESP      = rresp_q;
    assign core_key   = key_q;
    assign core_din   = din_q;
    assign core_mode  = mode_q;
    assign core_start = start_q;

    // Byte-offset bits are not decoded.
    assign unused_bits = ^{AWADDR[1:0], ARADDR[1:0]};

endmodule

// File: tb/tb_aesip_axil_regs.sv
module tb_aesip_axil_regs;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [5:0]   AWADDR;
    logic         AWVALID;
    logic         AWREADY;
    logic [31:0]  WDATA;
    logic [3:0]   WSTRB;
    logic         WVALID;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY;
    logic [5:0]   ARADDR;
    logic         ARVALID;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY;
    logic [127:0] core_key;
    logic [127:0] core_din;
    logic         core_mode;
    logic         core_start;
    logic [127:0] core_dout;
    logic         core_done;

    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;

    int tests = 0;
    int fails = 0;
    int start_cnt = 0;
    int start_base;

    aesip_axil_regs #(.ADDR_W(6), .DATA_W(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .core_key(core_key), .core_din(core_din), .core_mode(core_mode),
        .core_start(core_start), .core_dout(core_dout), .core_done(core_done)
    );

    always #5 ACLK = ~ACLK;

    // Counts clock edges at which core_start was high.
    always @(posedge ACLK) begin
        if (core_start === 1'b1) start_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit   aw_ok = 0;
        bit   w_ok  = 0;
        int   n     = 0;
        logic awr, wr;
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
        while (!(aw_ok && w_ok) && n < 50) begin
            awr = AWREADY;
            wr  = WREADY;
            tick();
            n++;
            if (AWVALID && awr) begin aw_ok = 1; AWVALID = 1'b0; end
            if (WVALID && wr)   begin w_ok  = 1; WVALID  = 1'b0; end
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        n = 0;
        while (BVALID !== 1'b1 && n < 50) begin tick(); n++; end
        check("wr_bvalid_seen", BVALID, 1'b1);
        resp   = BRESP;
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit   ar_ok = 0;
        int   n     = 0;
        logic arr;
        ARADDR = a; ARVALID = 1'b1;
        while (!ar_ok && n < 50) begin
            arr = ARREADY;
            tick();
            n++;
            if (arr) begin ar_ok = 1; ARVALID = 1'b0; end
        end
        ARVALID = 1'b0;
        n = 0;
        while (RVALID !== 1'b1 && n < 50) begin tick(); n++; end
        check("rd_rvalid_seen", RVALID, 1'b1);
        d      = RDATA;
        resp   = RRESP;
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input logic [5:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] exp_resp);
        logic [1:0] r;
        axi_write(a, d, s, r);
        check(tag, r, exp_resp);
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp_d,
                          input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(a, d, r);
        check({tag, "_data"}, d, exp_d);
        check({tag, "_resp"}, r, exp_resp);
    endtask

    initial begin
        ARESET = 1'b1;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
        core_dout = '0; core_done = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_awready", AWREADY, 1'b1);
        check("rst_wready", WREADY, 1'b1);
        check("rst_arready", ARREADY, 1'b1);
        check("rst_bvalid", BVALID, 1'b0);
        check("rst_rvalid", RVALID, 1'b0);
        check("rst_core_start", core_start, 1'b0);
        check("rst_core_key", core_key, 128'h0);
        ARESET = 1'b0;
        tick();

        // KEY0..3 write and readback
        for (int i = 0; i < 4; i++) wr_chk("key_wr_resp", 6'(6'h10 + 4 * i), 32'(i + 1), 4'hF, OK);
        for (int i = 0; i < 4; i++) rd_chk("key_rd", 6'(6'h10 + 4 * i), 32'(i + 1), OK);
        check("core_key", core_key, 128'h00000004_00000003_00000002_00000001);

        // AW three cycles ahead of W, response held with BREADY low
        AWADDR = 6'h20; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        check("split_awready_low", AWREADY, 1'b0);
        check("split_wready_high", WREADY, 1'b1);
        repeat (3) begin
            tick();
            check("split_no_bvalid", BVALID, 1'b0);
        end
        check("split_din_untouched", core_din, 128'h0);
        WDATA = 32'h11223344; WSTRB = 4'hF; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        check("split_bvalid", BVALID, 1'b1);
        check("split_din_updated", core_din, {96'h0, 32'h11223344});
        repeat (4) begin
            tick();
            check("b_hold_valid", BVALID, 1'b1);
            check("b_hold_resp", BRESP, OK);
            check("b_hold_awready", AWREADY, 1'b0);
            check("b_hold_wready", WREADY, 1'b0);
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("b_done_bvalid", BVALID, 1'b0);
        check("b_done_awready", AWREADY, 1'b1);
        check("b_done_wready", WREADY, 1'b1);
        rd_chk("split_din0", 6'h20, 32'h11223344, OK);

        // START, re-START while busy, busy-protected DIN write
        start_base = start_cnt;
        wr_chk("start_resp", 6'h00, 32'h1, 4'hF, OK);
        check("start_one_pulse", 32'(start_cnt - start_base), 32'd1);
        rd_chk("status_busy", 6'h04, 32'h1, OK);
        rd_chk("ctrl_start_reads0", 6'h00, 32'h0, OK);
        wr_chk("restart_resp", 6'h00, 32'h1, 4'hF, OK);
        check("restart_no_pulse", 32'(start_cnt - start_base), 32'd1);
        rd_chk("status_busy_err", 6'h04, 32'h5, OK);
        wr_chk("din_busy_resp", 6'h20, 32'hDEADBEEF, 4'hF, ERR);
        rd_chk("din_busy_kept", 6'h20, 32'h11223344, OK);
        wr_chk("w1c_err_resp", 6'h04, 32'h4, 4'hF, OK);
        rd_chk("status_err_clr", 6'h04, 32'h1, OK);

        // Core completion
        core_dout = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        rd_chk("dout0", 6'h30, 32'h70b4c55a, OK);
        rd_chk("dout3", 6'h3C, 32'h69c4e0d8, OK);
        rd_chk("status_done", 6'h04, 32'h2, OK);
        wr_chk("w1c_resp", 6'h04, 32'h6, 4'hF, OK);
        rd_chk("status_cleared", 6'h04, 32'h0, OK);

        // MODE write while idle
        start_base = start_cnt;
        wr_chk("mode_resp", 6'h00, 32'h2, 4'hF, OK);
        rd_chk("ctrl_mode", 6'h00, 32'h2, OK);
        check("core_mode", core_mode, 1'b1);
        check("mode_no_pulse", 32'(start_cnt - start_base), 32'd0);

        // Unmapped and read-only offsets, byte strobes
        rd_chk("hole_rd", 6'h08, 32'h0, ERR);
        wr_chk("hole_wr_resp", 6'h08, 32'h12345678, 4'hF, ERR);
        wr_chk("ro_wr_resp", 6'h3C, 32'h12345678, 4'hF, OK);
        rd_chk("ro_dout3_kept", 6'h3C, 32'h69c4e0d8, OK);
        wr_chk("strb_resp", 6'h14, 32'hAABBCCDD, 4'b0010, OK);
        rd_chk("strb_key1", 6'h14, 32'h0000CC02, OK);

        // Reset while a write response is pending
        AWADDR = 6'h18; WDATA = 32'h55555555; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        check("pre_rst_bvalid", BVALID, 1'b1);
        ARESET = 1'b1;
        #1;
        check("async_rst_bvalid", BVALID, 1'b0);
        check("async_rst_awready", AWREADY, 1'b1);
        check("async_rst_key", core_key, 128'h0);
        tick(); tick();
        ARESET = 1'b0;
        tick();
        rd_chk("post_rst_key1", 6'h14, 32'h0, OK);
        rd_chk("post_rst_din0", 6'h20, 32'h0, OK);
        rd_chk("post_rst_dout3", 6'h3C, 32'h0, OK);
        rd_chk("post_rst_status", 6'h04, 32'h0, OK);
        rd_chk("post_rst_ctrl", 6'h00, 32'h0, OK);

        // A core_done arriving after reset is still captured
        core_dout = 128'h00000004_00000003_00000002_cafef00d;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        rd_chk("late_done_dout0", 6'h30, 32'hcafef00d, OK);
        rd_chk("late_done_status", 6'h04, 32'h2, OK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
